// File: rtl/data_pack_pkg.sv
// Shared constants and helpers for the C2H data packer and its FIFO.
// Frames are laid out as {payload, seq}, with the sequence tag in the low bits.
package data_pack_pkg;

   localparam int DATA_W_DEF = 4064;
   localparam int SEQ_W_DEF  = 8;
   localparam int DEPTH_DEF  = 4;

   // The tag sits at the bottom of the frame; the payload starts right above it.
   localparam int SEQ_LSB    = 0;

   function automatic int frame_w(input int data_w, input int seq_w);
      return data_w + seq_w;
   endfunction

   function automatic int data_lsb(input int seq_w);
      return SEQ_LSB + seq_w;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with an occupancy counter and a synchronous clear.
// The head entry is presented on rd_data without a read request; rd_en pops it.
module sync_fifo_fwft #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [CNT_W-1:0] level
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_level;
   logic             w_do_wr;
   logic             w_do_rd;

   assign empty   = (r_level == '0);
   assign full    = (r_level == CNT_W'(DEPTH));
   assign level   = r_level;

   // A write into a full FIFO is still legal when the head leaves in the same cycle.
   assign w_do_rd = rd_en && !empty;
   assign w_do_wr = wr_en && (!full || w_do_rd);

   // Zero the head while empty so the output reads 0 out of reset without clearing the array.
   assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_wr, w_do_rd})
            2'b10:   r_level <= r_level + CNT_W'(1);
            2'b01:   r_level <= r_level - CNT_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage has no reset so it can map onto distributed or block RAM.
   always_ff @(posedge clk) begin
      if (w_do_wr && !clr) r_mem[r_wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/data_pack_fifo.sv
// C2H data packer: captures a producer word on each rising edge of in_enable, tags it with a
// wrapping sequence number and buffers the frames for the XDMA C2H stream.
module data_pack_fifo
   import data_pack_pkg::*;
#(
   parameter  int DATA_W  = DATA_W_DEF,
   parameter  int SEQ_W   = SEQ_W_DEF,
   parameter  int DEPTH   = DEPTH_DEF,
   localparam int CNT_W   = $clog2(DEPTH) + 1,
   localparam int FRAME_W = frame_w(DATA_W, SEQ_W)
) (
   input  logic               m_axis_c2h_aclk,
   input  logic               m_axis_c2h_aresetn,
   input  logic               flush,
   input  logic               in_enable,
   input  logic [DATA_W-1:0]  in_data,
   output logic [FRAME_W-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SEQ_W-1:0]   seq_num,
   output logic [CNT_W-1:0]   level,
   output logic               hbreak,
   output logic               overflow
);

   logic               r_last_en;
   logic [SEQ_W-1:0]   r_seq;
   logic               r_overflow;
   logic               w_cap;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic [FRAME_W-1:0] w_frame;

   assign w_cap   = in_enable && !r_last_en;
   assign w_pop   = out_valid && out_ready;
   assign w_push  = w_cap && (!w_full || w_pop) && !flush;
   assign w_frame = {in_data, r_seq};

   assign out_valid = !w_empty;
   assign seq_num   = r_seq;
   assign overflow  = r_overflow;
   assign hbreak    = w_full && in_enable;

   always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
      if (!m_axis_c2h_aresetn) begin
         r_last_en  <= 1'b0;
         r_seq      <= '0;
         r_overflow <= 1'b0;
      end else if (flush) begin
         // Clearing last_en lets an enable still held high re-capture on the next cycle.
         r_last_en  <= 1'b0;
         r_seq      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_last_en <= in_enable;
         if (w_push) r_seq <= r_seq + SEQ_W'(1);
         if (w_cap && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (FRAME_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (m_axis_c2h_aclk),
      .rst_n   (m_axis_c2h_aresetn),
      .clr     (flush),
      .wr_en   (w_push),
      .wr_data (w_frame),
      .full    (w_full),
      .rd_en   (w_pop && !flush),
      .rd_data (out_data),
      .empty   (w_empty),
      .level   (level)
   );

endmodule

// File: tb/tb_data_pack_fifo.sv
// Directed bench for data_pack_fifo: a queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_data_pack_fifo;

   localparam int DW    = 4064;
   localparam int SW    = 8;
   localparam int DEPTH = 4;
   localparam int FW    = DW + SW;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_enable = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [FW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [SW-1:0] seq_num;
   logic [CW-1:0] level;
   logic          hbreak;
   logic          overflow;

   int total = 0;
   int bad   = 0;

   data_pack_fifo dut (
      .m_axis_c2h_aclk    (clk),
      .m_axis_c2h_aresetn (rst_n),
      .flush              (flush),
      .in_enable          (in_enable),
      .in_data            (in_data),
      .out_data           (out_data),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .seq_num            (seq_num),
      .level              (level),
      .hbreak             (hbreak),
      .overflow           (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (low 64 bits) at %0t", nm, act[63:0], exp[63:0], $time);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int k);
      logic [31:0] w;
      w = 32'hA5A5_A5A5 ^ k;
      return {127{w}};
   endfunction

   // Reference model: a plain queue of frames updated once per clock from the spec rules.
   logic [FW-1:0] mq[$];
   int            m_seq  = 0;
   bit            m_ovf  = 0;
   bit            m_last = 0;
   bit            m_cap;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_seq = 0; m_ovf = 0; m_last = 0;
      end else if (flush) begin
         mq.delete();
         m_seq = 0; m_ovf = 0; m_last = 0;
      end else begin
         m_cap = in_enable && !m_last;
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (m_cap) begin
            if (mq.size() < DEPTH) begin
               mq.push_back({in_data, 8'(m_seq)});
               m_seq = (m_seq + 1) % 256;
            end else begin
               m_ovf = 1;
            end
         end
         m_last = in_enable;
      end
   end

   always @(negedge clk) begin
      chk("m_valid",    FW'(out_valid), FW'(mq.size() > 0));
      chk("m_level",    FW'(level),     FW'(mq.size()));
      chk("m_seq",      FW'(seq_num),   FW'(m_seq));
      chk("m_overflow", FW'(overflow),  FW'(m_ovf));
      chk("m_hbreak",   FW'(hbreak),    FW'((mq.size() == DEPTH) && in_enable));
      if (mq.size() > 0) chk("m_data", out_data, mq[0]);
   end

   initial begin
      #100us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int k);
      in_data = mk(k);
      in_enable = 1'b1;
      step();
      in_enable = 1'b0;
      step();
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   initial begin
      in_enable = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("rst_valid",    FW'(out_valid), '0);
      chk("rst_data",     out_data,       '0);
      chk("rst_level",    FW'(level),     '0);
      chk("rst_seq",      FW'(seq_num),   '0);
      chk("rst_overflow", FW'(overflow),  '0);
      chk("rst_hbreak",   FW'(hbreak),    '0);
      in_enable = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // 1: single capture, first-word fall-through
      in_data = mk(32'hA5);
      in_enable = 1'b1;
      step();
      @(negedge clk);
      chk("t1_valid", FW'(out_valid),     FW'(1));
      chk("t1_tag",   FW'(out_data[7:0]), FW'(0));
      chk("t1_data",  out_data,           {mk(32'hA5), 8'h00});
      chk("t1_seq",   FW'(seq_num),       FW'(1));
      chk("t1_level", FW'(level),         FW'(1));
      in_enable = 1'b0;
      step();

      // 2: enable held high -> one capture
      do_flush();
      in_data = mk(2);
      in_enable = 1'b1;
      repeat (10) step();
      @(negedge clk);
      chk("t2_level", FW'(level),   FW'(1));
      chk("t2_seq",   FW'(seq_num), FW'(1));
      in_enable = 1'b0;
      step();

      // 3: fill to DEPTH, fifth edge dropped
      do_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) pulse(16 + i);
      in_data = mk(99);
      in_enable = 1'b1;
      #1;
      chk("t3_hbreak", FW'(hbreak), FW'(1));
      step();
      in_enable = 1'b0;
      @(negedge clk);
      chk("t3_level",    FW'(level),    FW'(4));
      chk("t3_overflow", FW'(overflow), FW'(1));
      chk("t3_seq",      FW'(seq_num),  FW'(4));
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t3_drain_tag", FW'(out_data[7:0]), FW'(i));
         step();
      end
      out_ready = 1'b0;
      @(negedge clk);
      chk("t3_empty", FW'(out_valid), FW'(0));
      step();

      // 4: capture and pop in the same cycle while full
      do_flush();
      for (int i = 0; i < 4; i++) pulse(32 + i);
      in_data = mk(36);
      in_enable = 1'b1;
      out_ready = 1'b1;
      step();
      in_enable = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("t4_level",    FW'(level),         FW'(4));
      chk("t4_overflow", FW'(overflow),      FW'(0));
      chk("t4_head",     FW'(out_data[7:0]), FW'(1));
      step();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("t4_drain_tag", FW'(out_data[7:0]), FW'(i));
         step();
      end
      out_ready = 1'b0;

      // 5: sequence wrap across 257 captures
      do_flush();
      out_ready = 1'b1;
      for (int i = 0; i < 257; i++) begin
         in_data = mk(1000 + i);
         in_enable = 1'b1;
         step();
         @(negedge clk);
         if (i >= 254) chk("t5_wrap_tag", FW'(out_data[7:0]), FW'(i % 256));
         in_enable = 1'b0;
         step();
      end
      @(negedge clk);
      chk("t5_seq",   FW'(seq_num), FW'(1));
      chk("t5_level", FW'(level),   FW'(0));
      out_ready = 1'b0;
      step();

      // 6: flush with enable high, then async reset mid-drain
      do_flush();
      for (int i = 0; i < 3; i++) pulse(50 + i);
      @(negedge clk);
      chk("t6_level3", FW'(level), FW'(3));
      in_data = mk(60);
      in_enable = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("t6_flush_level", FW'(level),    FW'(0));
      chk("t6_flush_ovf",   FW'(overflow), FW'(0));
      chk("t6_flush_valid", FW'(out_valid), FW'(0));
      step();
      @(negedge clk);
      chk("t6_recap_level", FW'(level),         FW'(1));
      chk("t6_recap_tag",   FW'(out_data[7:0]), FW'(0));
      chk("t6_recap_seq",   FW'(seq_num),       FW'(1));
      in_enable = 1'b0;
      step();
      pulse(61);
      pulse(62);
      out_ready = 1'b1;
      in_enable = 1'b1;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid",    FW'(out_valid), '0);
      chk("ar_data",     out_data,       '0);
      chk("ar_level",    FW'(level),     '0);
      chk("ar_seq",      FW'(seq_num),   '0);
      chk("ar_overflow", FW'(overflow),  '0);
      chk("ar_hbreak",   FW'(hbreak),    '0);
      repeat (2) step();
      in_enable = 1'b0;
      out_ready = 1'b0;
      rst_n = 1'b1;
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
